// File: rtl/sdram_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the SDRAM command scheduler: bus widths, the
// buffered command record and the scheduler FSM encoding.
package sdram_pkg;

  // Word address and burst data widths; both must match sdram_controller.
  localparam int ADDR_W = 22;
  localparam int DATA_W = 128;

  // One host command as it sits in the FIFO and in the issue register.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Scheduler states; encoding fixed so it reads the same in waveforms.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  // Bundle the host-side command fields into one FIFO record.
  function automatic cmd_t make_cmd(input logic              we,
                                    input logic [ADDR_W-1:0] address,
                                    input logic [DATA_W-1:0] wdata);
    cmd_t c;
    c.we      = we;
    c.address = address;
    c.wdata   = wdata;
    return c;
  endfunction

endpackage

// File: rtl/sdram_cmd_fifo.sv
`timescale 1ns/1ps
// Synchronous command FIFO with asynchronous reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. A push while full and a pop while
// empty are dropped. The head entry is presented combinationally from the
// storage array so the consumer can capture it on the same edge it pops.
module sdram_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers; reset discards all queued entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage write; contents need no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/sdram_cmd_scheduler.sv
`timescale 1ns/1ps
// Upstream request stage for sdram_controller.
// Host commands are queued in sdram_cmd_fifo; the FSM pops one at a time
// (only while the controller reports init done), drives a single-cycle
// write or read request, then waits for the matching ack. Requests are
// registered: a command accepted at edge N is popped at edge N+1, so the
// request is high during the cycle the controller samples at edge N+2.
// Address/data buses come straight from the issue register, so they are
// stable from the request cycle until the ack is taken. A missing ack
// aborts the command after ACK_TIMEOUT cycles in WAIT_ACK.
module sdram_cmd_scheduler
  import sdram_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iinit_done,
  input  logic              icmd_valid,
  output logic              ocmd_ready,
  input  logic              icmd_we,
  input  logic [ADDR_W-1:0] icmd_address,
  input  logic [DATA_W-1:0] icmd_wdata,
  output logic              ordata_valid,
  output logic [DATA_W-1:0] ordata,
  output logic              owr_done,
  output logic              oerr_timeout,
  output logic              obusy,
  output logic              owrite_req,
  output logic [ADDR_W-1:0] owrite_address,
  output logic [DATA_W-1:0] owrite_data,
  input  logic              iwrite_ack,
  output logic              oread_req,
  output logic [ADDR_W-1:0] oread_address,
  input  logic [DATA_W-1:0] iread_data,
  input  logic              iread_ack
);

  localparam int                CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state;
  cmd_t             cmd;
  logic [CNT_W-1:0] ack_cnt;

  cmd_t             fifo_din;
  cmd_t             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign fifo_din   = make_cmd(icmd_we, icmd_address, icmd_wdata);
  assign ocmd_ready = ~fifo_full;
  assign push       = icmd_valid & ~fifo_full;
  // Commands keep queueing while the controller initialises; only the pop is gated.
  assign pop        = (state == IDLE) & iinit_done & ~fifo_empty;
  assign obusy      = ~fifo_empty | (state != IDLE);

  // Controller-side buses are views of the issue register.
  assign owrite_address = cmd.address;
  assign owrite_data    = cmd.wdata;
  assign oread_address  = cmd.address;

  sdram_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iclk),
    .rst   (ireset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Command FSM: pop, issue one request, then wait for its ack or time out.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state        <= IDLE;
      cmd          <= '0;
      ack_cnt      <= '0;
      owrite_req   <= 1'b0;
      oread_req    <= 1'b0;
      owr_done     <= 1'b0;
      ordata_valid <= 1'b0;
      oerr_timeout <= 1'b0;
      ordata       <= '0;
    end else begin
      // Every host/controller strobe is a single-cycle pulse.
      owrite_req   <= 1'b0;
      oread_req    <= 1'b0;
      owr_done     <= 1'b0;
      ordata_valid <= 1'b0;
      oerr_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cmd        <= fifo_head;
            owrite_req <= fifo_head.we;
            oread_req  <= ~fifo_head.we;
            ack_cnt    <= '0;
            state      <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          // Acks seen here belong to nothing we issued; ignore them.
          ack_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (cmd.we && iwrite_ack) begin
            owr_done <= 1'b1;
            state    <= IDLE;
          end else if (!cmd.we && iread_ack) begin
            ordata       <= iread_data;
            ordata_valid <= 1'b1;
            state        <= IDLE;
          end else if (ack_cnt == CNT_LAST) begin
            // WAIT_ACK has now lasted ACK_TIMEOUT cycles; drop the command.
            oerr_timeout <= 1'b1;
            state        <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
`timescale 1ns/1ps
// Directed testbench for sdram_cmd_scheduler with a hand-driven controller mock.
module tb_sdram_cmd_scheduler;
  import sdram_pkg::*;

  localparam int TMO = 16;
  localparam logic [DATA_W-1:0] PAT = 128'hDEADBEEFCAFEBABE123456789ABCDEF0;

  logic              iclk = 1'b0;
  logic              ireset = 1'b0;
  logic              iinit_done = 1'b0;
  logic              icmd_valid = 1'b0;
  logic              ocmd_ready;
  logic              icmd_we = 1'b0;
  logic [ADDR_W-1:0] icmd_address = '0;
  logic [DATA_W-1:0] icmd_wdata = '0;
  logic              ordata_valid;
  logic [DATA_W-1:0] ordata;
  logic              owr_done;
  logic              oerr_timeout;
  logic              obusy;
  logic              owrite_req;
  logic [ADDR_W-1:0] owrite_address;
  logic [DATA_W-1:0] owrite_data;
  logic              iwrite_ack = 1'b0;
  logic              oread_req;
  logic [ADDR_W-1:0] oread_address;
  logic [DATA_W-1:0] iread_data = '0;
  logic              iread_ack = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [ADDR_W:0]   req_log[$];
  byte               done_log[$];
  logic [DATA_W-1:0] rdata_log[$];
  int                req_long = 0;
  logic              req_prev = 1'b0;

  always #5 iclk = ~iclk;

  sdram_cmd_scheduler #(
    .FIFO_DEPTH  (4),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .iclk           (iclk),
    .ireset         (ireset),
    .iinit_done     (iinit_done),
    .icmd_valid     (icmd_valid),
    .ocmd_ready     (ocmd_ready),
    .icmd_we        (icmd_we),
    .icmd_address   (icmd_address),
    .icmd_wdata     (icmd_wdata),
    .ordata_valid   (ordata_valid),
    .ordata         (ordata),
    .owr_done       (owr_done),
    .oerr_timeout   (oerr_timeout),
    .obusy          (obusy),
    .owrite_req     (owrite_req),
    .owrite_address (owrite_address),
    .owrite_data    (owrite_data),
    .iwrite_ack     (iwrite_ack),
    .oread_req      (oread_req),
    .oread_address  (oread_address),
    .iread_data     (iread_data),
    .iread_ack      (iread_ack)
  );

  // Mid-cycle monitor: logs requests and completions, flags requests wider than one cycle.
  always @(negedge iclk) begin
    if (owrite_req) req_log.push_back({1'b1, owrite_address});
    if (oread_req)  req_log.push_back({1'b0, oread_address});
    if ((owrite_req | oread_req) && req_prev) req_long++;
    req_prev = owrite_req | oread_req;
    if (owr_done) done_log.push_back("W");
    if (ordata_valid) begin
      done_log.push_back("R");
      rdata_log.push_back(ordata);
    end
    if (oerr_timeout) done_log.push_back("T");
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    done_log.delete();
    rdata_log.delete();
  endtask

  task automatic push(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    icmd_valid = 1'b1;
    icmd_we = we;
    icmd_address = a;
    icmd_wdata = d;
    tick();
    icmd_valid = 1'b0;
  endtask

  task automatic ack(input logic we, input logic [DATA_W-1:0] d);
    if (we) iwrite_ack = 1'b1;
    else begin
      iread_ack = 1'b1;
      iread_data = d;
    end
    tick();
    iwrite_ack = 1'b0;
    iread_ack = 1'b0;
  endtask

  task automatic wait_req(input int k, output bit ok);
    int n = 0;
    while (req_log.size() <= k && n < 60) begin
      tick();
      n++;
    end
    ok = (req_log.size() > k);
  endtask

  task automatic test_reset();
    #1 ireset = 1'b1;
    #2;
    tests_run++; if (ocmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %0b want 1", ocmd_ready); end
    tests_run++; if ({owrite_req, oread_req, owr_done, ordata_valid, oerr_timeout, obusy} !== 6'b0) begin tests_failed++; $display("FAIL reset_strobes: got %b want 000000", {owrite_req, oread_req, owr_done, ordata_valid, oerr_timeout, obusy}); end
    tests_run++; if ({owrite_address, oread_address, owrite_data, ordata} !== '0) begin tests_failed++; $display("FAIL reset_buses: got nonzero want 0"); end
    tick();
    tick();
    ireset = 1'b0;
    tick();
  endtask

  task automatic test_init_gate();
    clear_logs();
    iinit_done = 1'b0;
    push(1'b1, 22'h000001, PAT);
    push(1'b0, 22'h000001, '0);
    repeat (5) tick();
    tests_run++; if (req_log.size() !== 0) begin tests_failed++; $display("FAIL gate_no_req: got %0d reqs want 0", req_log.size()); end
    tests_run++; if (obusy !== 1'b1) begin tests_failed++; $display("FAIL gate_busy: got %0b want 1", obusy); end
    tests_run++; if (ocmd_ready !== 1'b1) begin tests_failed++; $display("FAIL gate_ready: got %0b want 1", ocmd_ready); end
    iinit_done = 1'b1;
    tick();
    tests_run++; if (owrite_req !== 1'b1) begin tests_failed++; $display("FAIL gate_first_req: got %0b want 1", owrite_req); end
    tests_run++; if (owrite_address !== 22'h000001 || owrite_data !== PAT) begin tests_failed++; $display("FAIL gate_first_bus: got %h/%h want 000001/%h", owrite_address, owrite_data, PAT); end
  endtask

  task automatic test_write();
    bit stable = 1'b1;
    tick();
    tests_run++; if (owrite_req !== 1'b0) begin tests_failed++; $display("FAIL write_req_width: got %0b want 0", owrite_req); end
    repeat (4) begin
      if (owrite_address !== 22'h000001 || owrite_data !== PAT || owrite_req || oread_req) stable = 1'b0;
      tick();
    end
    iwrite_ack = 1'b1;
    if (owrite_address !== 22'h000001 || owrite_data !== PAT) stable = 1'b0;
    tick();
    iwrite_ack = 1'b0;
    tests_run++; if (stable !== 1'b1) begin tests_failed++; $display("FAIL write_bus_stable: got %0b want 1", stable); end
    tests_run++; if (owr_done !== 1'b1) begin tests_failed++; $display("FAIL write_done: got %0b want 1", owr_done); end
    tick();
    tests_run++; if (owr_done !== 1'b0) begin tests_failed++; $display("FAIL write_done_width: got %0b want 0", owr_done); end
    tests_run++; if (oread_req !== 1'b1 || oread_address !== 22'h000001) begin tests_failed++; $display("FAIL write_next_read: got %0b/%h want 1/000001", oread_req, oread_address); end
  endtask

  task automatic test_read();
    tick();
    tests_run++; if (oread_req !== 1'b0) begin tests_failed++; $display("FAIL read_req_width: got %0b want 0", oread_req); end
    tick();
    ack(1'b0, PAT);
    tests_run++; if (ordata_valid !== 1'b1 || ordata !== PAT) begin tests_failed++; $display("FAIL read_data: got %0b/%h want 1/%h", ordata_valid, ordata, PAT); end
    iread_data = '0;
    tick();
    tests_run++; if (ordata_valid !== 1'b0 || ordata !== PAT) begin tests_failed++; $display("FAIL read_hold: got %0b/%h want 0/%h", ordata_valid, ordata, PAT); end
    tests_run++; if (obusy !== 1'b0 || done_log.size() !== 2) begin tests_failed++; $display("FAIL read_idle: got busy=%0b done=%0d want 0/2", obusy, done_log.size()); end
  endtask

  task automatic test_latency();
    push(1'b1, 22'h000040, PAT);
    tick();
    tests_run++; if (owrite_req !== 1'b1 || owrite_address !== 22'h000040) begin tests_failed++; $display("FAIL latency_req: got %0b/%h want 1/000040", owrite_req, owrite_address); end
    iwrite_ack = 1'b1;
    tick();
    iwrite_ack = 1'b0;
    tests_run++; if (owr_done !== 1'b0) begin tests_failed++; $display("FAIL issue_ack_ignored: got %0b want 0", owr_done); end
    ack(1'b1, '0);
    tests_run++; if (owr_done !== 1'b1) begin tests_failed++; $display("FAIL latency_done: got %0b want 1", owr_done); end
    tick();
  endtask

  task automatic test_fifo_full();
    logic              we_v [5];
    logic [ADDR_W-1:0] ad_v [5];
    logic [DATA_W-1:0] rd_v [5];
    logic [ADDR_W:0]   exp_req;
    bit                ok;
    byte               exp_done;
    clear_logs();
    for (int k = 0; k < 5; k++) begin
      we_v[k] = (k % 2 == 0);
      ad_v[k] = ADDR_W'(10 + k);
      rd_v[k] = {4{32'h5A5A0000 + 32'(k)}};
    end
    for (int k = 0; k < 5; k++) begin
      tests_run++; if (ocmd_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready_%0d: got %0b want 1", k, ocmd_ready); end
      icmd_valid = 1'b1;
      icmd_we = we_v[k];
      icmd_address = ad_v[k];
      icmd_wdata = PAT ^ DATA_W'(k);
      tick();
    end
    icmd_valid = 1'b0;
    tests_run++; if (ocmd_ready !== 1'b0) begin tests_failed++; $display("FAIL full_not_ready: got %0b want 0", ocmd_ready); end
    for (int k = 0; k < 5; k++) begin
      wait_req(k, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL full_req_seen_%0d: got %0b want 1", k, ok); end
      if (ok) begin
        exp_req = {we_v[k], ad_v[k]};
        tests_run++; if (req_log[k] !== exp_req) begin tests_failed++; $display("FAIL full_order_%0d: got %h want %h", k, req_log[k], exp_req); end
      end
      ack(we_v[k], rd_v[k]);
    end
    tick();
    tests_run++; if (done_log.size() !== 5) begin tests_failed++; $display("FAIL full_done_count: got %0d want 5", done_log.size()); end
    for (int k = 0; k < 5 && k < done_log.size(); k++) begin
      exp_done = we_v[k] ? "W" : "R";
      tests_run++; if (done_log[k] !== exp_done) begin tests_failed++; $display("FAIL full_done_%0d: got %c want %c", k, done_log[k], exp_done); end
    end
    tests_run++; if (rdata_log.size() !== 2) begin tests_failed++; $display("FAIL full_rdata_count: got %0d want 2", rdata_log.size()); end
    else begin
      tests_run++; if (rdata_log[0] !== rd_v[1] || rdata_log[1] !== rd_v[3]) begin tests_failed++; $display("FAIL full_rdata: got %h,%h want %h,%h", rdata_log[0], rdata_log[1], rd_v[1], rd_v[3]); end
    end
  endtask

  task automatic test_timeout();
    int  n = 0;
    bit  ok;
    clear_logs();
    push(1'b0, 22'h000020, '0);
    push(1'b1, 22'h000021, PAT);
    wait_req(0, ok);
    tests_run++; if (ok !== 1'b1 || req_log[0] !== {1'b0, 22'h000020}) begin tests_failed++; $display("FAIL tmo_first_req: got %0b want read of 000020", ok); end
    while (oerr_timeout !== 1'b1 && n < 40) begin
      iwrite_ack = (n == 3);
      tick();
      iwrite_ack = 1'b0;
      n++;
    end
    tests_run++; if (n !== TMO) begin tests_failed++; $display("FAIL tmo_latency: got %0d cycles want %0d", n, TMO); end
    tick();
    tests_run++; if (oerr_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_width: got %0b want 0", oerr_timeout); end
    wait_req(1, ok);
    tests_run++; if (ok !== 1'b1 || req_log[1] !== {1'b1, 22'h000021}) begin tests_failed++; $display("FAIL tmo_next_req: got %0b want write of 000021", ok); end
    ack(1'b1, '0);
    tick();
    tests_run++; if (done_log.size() !== 2 || done_log[0] !== "T" || done_log[1] !== "W") begin tests_failed++; $display("FAIL tmo_done_seq: got %0d entries want T,W", done_log.size()); end
    tests_run++; if (rdata_log.size() !== 0) begin tests_failed++; $display("FAIL tmo_no_rdata: got %0d want 0", rdata_log.size()); end
  endtask

  task automatic test_reset_mid();
    push(1'b1, 22'h000030, PAT);
    tick();
    tests_run++; if (owrite_req !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_req: got %0b want 1", owrite_req); end
    ireset = 1'b1;
    #1;
    tests_run++; if (owrite_req !== 1'b0 || obusy !== 1'b0) begin tests_failed++; $display("FAIL rst_async_req: got %0b/%0b want 0/0", owrite_req, obusy); end
    tick();
    ireset = 1'b0;
    tick();
    push(1'b1, 22'h000031, PAT);
    push(1'b0, 22'h000032, '0);
    push(1'b1, 22'h000033, PAT);
    push(1'b0, 22'h000034, '0);
    tests_run++; if (obusy !== 1'b1 || owrite_address !== 22'h000031) begin tests_failed++; $display("FAIL rst_busy_pre: got %0b/%h want 1/000031", obusy, owrite_address); end
    ireset = 1'b1;
    #1;
    tests_run++; if (ocmd_ready !== 1'b1 || obusy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_flags: got ready=%0b busy=%0b want 1/0", ocmd_ready, obusy); end
    tests_run++; if ({owrite_address, oread_address, owrite_data, ordata} !== '0) begin tests_failed++; $display("FAIL rst_mid_buses: got nonzero want 0"); end
    tick();
    ireset = 1'b0;
    tick();
    clear_logs();
    iwrite_ack = 1'b1;
    tick();
    iwrite_ack = 1'b0;
    iread_ack = 1'b1;
    tick();
    iread_ack = 1'b0;
    repeat (4) tick();
    tests_run++; if (done_log.size() !== 0 || req_log.size() !== 0) begin tests_failed++; $display("FAIL rst_stray_ack: got done=%0d req=%0d want 0/0", done_log.size(), req_log.size()); end
    tests_run++; if (obusy !== 1'b0) begin tests_failed++; $display("FAIL rst_fifo_empty: got %0b want 0", obusy); end
  endtask

  task automatic test_req_pulse_width();
    tests_run++; if (req_long !== 0) begin tests_failed++; $display("FAIL req_pulse_width: got %0d long pulses want 0", req_long); end
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_write();
    test_read();
    test_latency();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    test_req_pulse_width();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
